// File: rtl/usb_rx_packet_fifo_if.sv
// rtl/usb_rx_packet_fifo_if.sv - receive-side and consumer-side signals of the USB packet FIFO
interface usb_rx_packet_fifo_if #(
    parameter int ADDR_W = 6
);
    logic              receiving;
    logic              write_enable;
    logic [7:0]        rx_data;
    logic              rcv_error;
    logic              read_enable;
    logic [7:0]        r_data;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic [3:0]        pkt_pid;
    logic              pid_valid;
    logic              pkt_ready;
    logic              pkt_dropped;
    logic              overflow;

    modport master (
        output receiving, write_enable, rx_data, rcv_error, read_enable,
        input  r_data, empty, count, pkt_pid, pid_valid, pkt_ready, pkt_dropped, overflow
    );

    modport slave (
        input  receiving, write_enable, rx_data, rcv_error, read_enable,
        output r_data, empty, count, pkt_pid, pid_valid, pkt_ready, pkt_dropped, overflow
    );
endinterface

// File: rtl/usb_rx_packet_fifo.sv
// rtl/usb_rx_packet_fifo.sv - PID-checked packet FIFO with speculative write, commit and rollback
module usb_rx_packet_fifo #(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int CRC_BYTES = 2
) (
    input  logic                   clk,
    input  logic                   n_rst,
    usb_rx_packet_fifo_if.slave    bus
);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CRC_W   = (ADDR_W + 1)'(CRC_BYTES);

    typedef enum logic [1:0] {IDLE, PID, PAYLOAD, DROP} state_t;

    state_t          state, state_next;
    logic [7:0]      mem [DEPTH];
    logic [ADDR_W:0] rptr, commit_wptr, spec_wptr, payload_cnt, space_used;
    logic [3:0]      pid_shadow, pkt_pid_r;
    logic            receiving_q, rise, fall, pop;
    logic            pid_valid_r, pkt_ready_r, pkt_dropped_r, overflow_r;
    logic            do_start, do_pid, do_write, do_commit, do_drop, do_ovf;

    assign rise       = bus.receiving & ~receiving_q;
    assign fall       = ~bus.receiving & receiving_q;
    assign space_used = spec_wptr - rptr;
    assign pop        = bus.read_enable & ~bus.empty;

    assign bus.empty       = (commit_wptr == rptr);
    assign bus.count       = commit_wptr - rptr;
    assign bus.r_data      = mem[rptr[ADDR_W-1:0]];
    assign bus.pkt_pid     = pkt_pid_r;
    assign bus.pid_valid   = pid_valid_r;
    assign bus.pkt_ready   = pkt_ready_r;
    assign bus.pkt_dropped = pkt_dropped_r;
    assign bus.overflow    = overflow_r;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath strobes; end of packet outranks everything else
    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_pid     = 1'b0;
        do_write   = 1'b0;
        do_commit  = 1'b0;
        do_drop    = 1'b0;
        do_ovf     = 1'b0;
        if (fall && state != IDLE) begin
            state_next = IDLE;
            if (state == PAYLOAD && payload_cnt >= CRC_W && !bus.rcv_error) begin
                do_commit = 1'b1;
            end else begin
                do_drop = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        do_start   = 1'b1;
                        state_next = PID;
                    end
                end
                PID: begin
                    if (bus.rcv_error) begin
                        state_next = DROP;
                    end else if (bus.write_enable) begin
                        if (bus.rx_data[3:0] == ~bus.rx_data[7:4]) begin
                            do_pid     = 1'b1;
                            state_next = PAYLOAD;
                        end else begin
                            state_next = DROP;
                        end
                    end
                end
                PAYLOAD: begin
                    if (bus.rcv_error) begin
                        state_next = DROP;
                    end else if (bus.write_enable) begin
                        if (space_used < DEPTH_W) begin
                            do_write = 1'b1;
                        end else begin
                            do_ovf     = 1'b1;
                            state_next = DROP;
                        end
                    end
                end
                DROP: begin
                    state_next = DROP;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Pointers, PID tracking and status pulses
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            receiving_q   <= 1'b0;
            rptr          <= '0;
            commit_wptr   <= '0;
            spec_wptr     <= '0;
            payload_cnt   <= '0;
            pid_shadow    <= '0;
            pkt_pid_r     <= '0;
            pid_valid_r   <= 1'b0;
            pkt_ready_r   <= 1'b0;
            pkt_dropped_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            receiving_q   <= bus.receiving;
            pkt_ready_r   <= do_commit;
            pkt_dropped_r <= do_drop;
            overflow_r    <= do_ovf;
            if (do_start || do_drop) begin
                spec_wptr <= commit_wptr;
            end else if (do_write) begin
                spec_wptr <= spec_wptr + 1'b1;
            end
            if (do_commit) begin
                commit_wptr <= spec_wptr - CRC_W;
                pkt_pid_r   <= pid_shadow;
                pid_valid_r <= 1'b1;
            end
            if (do_pid) begin
                pid_shadow  <= bus.rx_data[3:0];
                payload_cnt <= '0;
            end else if (do_write && payload_cnt != '1) begin
                payload_cnt <= payload_cnt + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Payload storage; contents are meaningless until committed, so no reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[spec_wptr[ADDR_W-1:0]] <= bus.rx_data;
        end
    end
endmodule

// File: tb/tb_usb_rx_packet_fifo.sv
// tb/tb_usb_rx_packet_fifo.sv - directed-vector bench for usb_rx_packet_fifo
module tb_usb_rx_packet_fifo;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   ready_n = 0, dropped_n = 0, ovf_n = 0;
    int   r0, d0, o0;

    usb_rx_packet_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    usb_rx_packet_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CRC_BYTES(2)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Pulse tallies sampled on the falling edge
    always @(negedge clk) begin
        ready_n   = ready_n + int'(bus.pkt_ready);
        dropped_n = dropped_n + int'(bus.pkt_dropped);
        ovf_n     = ovf_n + int'(bus.overflow);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input logic pop_too);
        bus.rx_data      = b;
        bus.write_enable = 1'b1;
        bus.read_enable  = pop_too;
        tick();
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
    endtask

    task automatic pkt_start;
        r0 = ready_n;
        d0 = dropped_n;
        o0 = ovf_n;
        bus.receiving = 1'b1;
        tick();
    endtask

    task automatic pkt_end;
        bus.receiving = 1'b0;
        tick();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check_val(tag, bus.r_data, exp);
        bus.read_enable = 1'b1;
        tick();
        bus.read_enable = 1'b0;
    endtask

    initial begin
        bus.receiving    = 1'b0;
        bus.write_enable = 1'b0;
        bus.rx_data      = 8'h00;
        bus.rcv_error    = 1'b0;
        bus.read_enable  = 1'b0;
        tick();
        tick();
        check_val("rst_empty", bus.empty, 1);
        check_val("rst_count", bus.count, 0);
        check_val("rst_pid_valid", bus.pid_valid, 0);
        check_val("rst_pkt_pid", bus.pkt_pid, 0);
        n_rst = 1'b1;
        tick();

        // Good packet
        pkt_start();
        wr(8'hC3, 0); wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0); wr(8'hAA, 0); wr(8'hBB, 0);
        check_val("good_precommit_empty", bus.empty, 1);
        pkt_end();
        check_val("good_count", bus.count, 3);
        check_val("good_pkt_ready_now", bus.pkt_ready, 1);
        check_val("good_pid", bus.pkt_pid, 4'h3);
        check_val("good_pid_valid", bus.pid_valid, 1);
        tick();
        check_val("good_ready_pulses", ready_n - r0, 1);
        pop_check("good_pop0", 8'h11);
        pop_check("good_pop1", 8'h22);
        pop_check("good_pop2", 8'h33);
        check_val("good_empty", bus.empty, 1);
        bus.read_enable = 1'b1;
        tick();
        bus.read_enable = 1'b0;
        check_val("empty_pop_count", bus.count, 0);

        // Error rollback then a clean packet
        pkt_start();
        wr(8'hC3, 0); wr(8'h44, 0); wr(8'h55, 0);
        bus.rcv_error = 1'b1;
        tick();
        pkt_end();
        bus.rcv_error = 1'b0;
        tick();
        check_val("err_dropped", dropped_n - d0, 1);
        check_val("err_count", bus.count, 0);
        pkt_start();
        wr(8'h4B, 0); wr(8'h66, 0); wr(8'h00, 0); wr(8'h00, 0);
        pkt_end();
        check_val("after_err_count", bus.count, 1);
        check_val("after_err_pid", bus.pkt_pid, 4'hB);
        pop_check("after_err_data", 8'h66);

        // Bad PID
        pkt_start();
        wr(8'hFF, 0); wr(8'h12, 0); wr(8'h34, 0); wr(8'h56, 0);
        pkt_end();
        tick();
        check_val("badpid_dropped", dropped_n - d0, 1);
        check_val("badpid_ready", ready_n - r0, 0);
        check_val("badpid_pid", bus.pkt_pid, 4'hB);
        check_val("badpid_pid_valid", bus.pid_valid, 1);
        check_val("badpid_count", bus.count, 0);

        // Overflow: four committed bytes, then 6 payload + 2 CRC
        pkt_start();
        wr(8'hD2, 0); wr(8'hA0, 0); wr(8'hA1, 0); wr(8'hA2, 0); wr(8'hA3, 0); wr(8'hC0, 0); wr(8'hC0, 0);
        pkt_end();
        check_val("ovf_pre_count", bus.count, 4);
        pkt_start();
        wr(8'hC3, 0); wr(8'hB0, 0); wr(8'hB1, 0); wr(8'hB2, 0); wr(8'hB3, 0);
        check_val("ovf_not_yet", bus.overflow, 0);
        wr(8'hB4, 0);
        check_val("ovf_on_5th", bus.overflow, 1);
        wr(8'hB5, 0); wr(8'hE0, 0); wr(8'hE1, 0);
        pkt_end();
        tick();
        check_val("ovf_pulses", ovf_n - o0, 1);
        check_val("ovf_dropped", dropped_n - d0, 1);
        check_val("ovf_count", bus.count, 4);
        pop_check("ovf_data0", 8'hA0);
        pop_check("ovf_data1", 8'hA1);
        pop_check("ovf_data2", 8'hA2);
        pop_check("ovf_data3", 8'hA3);

        // Pointer wrap, concurrent pop, short packet
        pkt_start();
        wr(8'hD2, 0);
        for (int i = 0; i < 6; i++) wr(8'h71 + 8'(i), 0);
        wr(8'hC0, 0); wr(8'hC1, 0);
        pkt_end();
        check_val("wrap_a_count", bus.count, 6);
        pop_check("wrap_a0", 8'h71);
        pop_check("wrap_a1", 8'h72);
        pop_check("wrap_a2", 8'h73);
        pop_check("wrap_a3", 8'h74);
        pkt_start();
        wr(8'h3C, 0); wr(8'h81, 0); wr(8'h82, 0); wr(8'h83, 0); wr(8'h90, 0); wr(8'h91, 0);
        pkt_end();
        check_val("wrap_b_count", bus.count, 5);
        check_val("wrap_b_pid", bus.pkt_pid, 4'hC);
        pkt_start();
        wr(8'hC3, 0);
        check_val("conc_pop_data", bus.r_data, 8'h75);
        wr(8'h99, 1);
        pkt_end();
        tick();
        check_val("short_dropped", dropped_n - d0, 1);
        check_val("short_count", bus.count, 4);
        pop_check("wrap_b0", 8'h76);
        pop_check("wrap_b1", 8'h81);
        pop_check("wrap_b2", 8'h82);
        pop_check("wrap_b3", 8'h83);
        check_val("wrap_empty", bus.empty, 1);

        // Reset in the middle of a packet
        pkt_start();
        wr(8'hC3, 0); wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0);
        n_rst = 1'b0;
        bus.receiving = 1'b0;
        #1;
        check_val("midrst_empty", bus.empty, 1);
        check_val("midrst_count", bus.count, 0);
        check_val("midrst_pid_valid", bus.pid_valid, 0);
        tick();
        n_rst = 1'b1;
        tick();
        pkt_start();
        wr(8'h4B, 0); wr(8'h5A, 0); wr(8'h5B, 0); wr(8'hEE, 0); wr(8'hEF, 0);
        pkt_end();
        check_val("postrst_count", bus.count, 2);
        check_val("postrst_pid", bus.pkt_pid, 4'hB);
        check_val("postrst_pid_valid", bus.pid_valid, 1);
        pop_check("postrst_data0", 8'h5A);
        pop_check("postrst_data1", 8'h5B);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
